// File: rtl/prog_loader.sv
// Program RAM and download engine for the micro core.
// Holds the core in reset while a program streams in, then serves fetches.
module prog_loader #(
  parameter int          INST_W   = 13,
  parameter int          ADDR_W   = 8,
  parameter int          DEPTH    = 256,
  parameter logic [12:0] NOP_INST = 13'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_last,
  input  logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              cpu_reset,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic [INST_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow;

  logic w_full;
  logic w_accept;
  logic w_start;

  assign w_full   = (r_count == LP_DEPTH);
  assign w_accept = load_valid && load_ready;
  assign w_start  = load_start && (r_state != S_LOAD);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (load_start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_full)
          w_next = S_IDLE;
        else if (w_accept && load_last)
          w_next = S_RUN;
      end
      S_RUN:  if (load_start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_reset  = 1'b1;
    done       = 1'b0;
    load_ready = 1'b0;
    unique case (r_state)
      S_LOAD: load_ready = !w_full;
      S_RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Acceptance stops at DEPTH, so the write pointer never wraps onto data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_addr  <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_wr_addr  <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == S_LOAD) begin
      if (w_full) begin
        r_overflow <= 1'b1;
      end else if (w_accept) begin
        r_wr_addr <= r_wr_addr + 1'b1;
        r_count   <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_accept)
      r_mem[r_wr_addr] <= load_data;
  end

  // Words beyond the current load read as NOP, hiding stale programs.
  assign inst     = ({1'b0, pc} < r_count) ? r_mem[pc] : NOP_INST;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program memory and loader for the `micro` core.
- Accepts 13-bit instruction words over a valid/ready write stream and stores them in an internal program RAM.
- Holds the core in reset while loading, then releases it and serves `inst` from the address on the core's `pc`.
- This is the write/serve side of the core's instruction-fetch interface. It replaces a fixed ROM, so benches and the top level can download programs at run time.

Parameters:
- INST_W, 13, instruction word width.
- ADDR_W, 8, program address width; must match core `pc` width.
- DEPTH, 256, program RAM words; must be ≤ 2**ADDR_W.
- NOP_INST, 13'h0000, word returned for addresses not written in the current load.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle request to begin a new program download.
- load_valid  input  1  load_data/load_last are valid.
- load_ready  output  1  loader can accept a word this cycle.
- load_data  input  INST_W  instruction word to store.
- load_last  input  1  current word is the final word of the program.
- pc  input  ADDR_W  fetch address from the core.
- inst  output  INST_W  instruction at pc, to the core.
- cpu_reset  output  1  reset to the core; high while not running.
- done  output  1  program loaded, core running.
- overflow  output  1  sticky: load exceeded DEPTH without load_last.
- count  output  ADDR_W+1  words stored by the current or last load.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, wr_addr=0, count=0, overflow=0.
  - Outputs: cpu_reset=1, load_ready=0, done=0.
  - RAM contents are not cleared.
  - reset has priority over every other input, including mid-load; a partial load is abandoned and count returns to 0.
- States: IDLE, LOAD, RUN.
- Decoded outputs:
  - cpu_reset = (state != RUN).
  - done = (state == RUN).
  - load_ready = (state == LOAD) && (count < DEPTH).
- IDLE:
  - load_start=1 → LOAD next cycle; wr_addr←0, count←0, overflow←0.
  - load_valid is ignored.
- LOAD:
  - A beat is accepted when load_valid && load_ready on the edge: mem[wr_addr]←load_data, wr_addr←wr_addr+1, count←count+1.
  - Accepted beat with load_last=1 → RUN next cycle. cpu_reset falls in the first cycle after the accepting edge; latency from last beat to core release is 1 cycle.
  - load_last without load_valid has no effect.
  - load_start in LOAD is ignored; no restart mid-load.
  - count reaches DEPTH with no last accepted: load_ready=0 that cycle, next edge → IDLE with overflow←1. Core stays in reset. A word offered while load_ready=0 is not written.
  - A single-word program (first beat has load_last=1) is legal → RUN with count=1.
- RUN:
  - Core executes.
  - load_start=1 → LOAD next cycle; cpu_reset re-asserts from that cycle; wr_addr←0, count←0.
  - load_valid is ignored.
- Fetch path:
  - Combinational, asynchronous read: inst = (pc < count) ? mem[pc] : NOP_INST.
  - Valid in every state; the core is held in reset outside RUN.
  - Zero-latency, so core fetch timing is unchanged versus a ROM.
- Width rules:
  - wr_addr is ADDR_W bits. It never wraps, because acceptance stops at count==DEPTH.
  - count is ADDR_W+1 bits so DEPTH=256 is representable.
  - pc is compared against the zero-extended count.
- Write/read same cycle: a read of the address being written returns the old contents until the edge (only observable in LOAD, core in reset).

Test Plan:
- reset=1 for 5 cycles → cpu_reset=1, done=0, load_ready=0, count=0, overflow=0, inst=13'h0000 for pc=0.
- load_start, then 4 words 13'h1A01, 13'h0C02, 13'h1F03, 13'h0004 (last on 4th), valid every cycle → load_ready=1 throughout; cpu_reset falls 1 cycle after the 4th edge; done=1; count=4; pc=2 → inst=13'h1F03; pc=4 → 13'h0000.
- Same load with load_valid toggling 1,0,1,0… → identical RAM contents and count=4; gaps stall without writes.
- Stream 256 words, load_last never set → load_ready=0 once count=256; next edge overflow=1, state IDLE, cpu_reset=1; extra word not written. Then load_start clears overflow.
- After a 4-word load in RUN: load_start, 2 words 13'h0111, 13'h0222 (last) → cpu_reset=1 during load; count=2; pc=2 → NOP_INST, old word hidden.
- Assert reset after 2 of 4 beats → count=0, IDLE, cpu_reset=1; remaining beats ignored (load_ready=0).
